// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types, default widths and round-robin search for the RAM bus arbiter
package bus_pkg;

  typedef enum logic [1:0] {IDLE, WRITE, READ, GRANT} bus_state_t;

  localparam int N_CORES_DEF = 4;
  localparam int DW_DEF      = 8;
  localparam int CORE_AW_DEF = 10;
  localparam int RAM_AW_DEF  = 9;
  localparam int RD_LAT_DEF  = 1;
  localparam int MAX_CORES   = 16;

  // Returns {found, index} of the first requester after ptr, wrapping modulo n.
  // Scanned farthest-first so the nearest requester is the last assignment.
  function automatic logic [4:0] rr_next(input logic [MAX_CORES-1:0] req,
                                         input logic [3:0] ptr, input int n);
    logic [4:0] r;
    logic [3:0] c;
    r = '0;
    for (int i = MAX_CORES; i >= 1; i--) begin
      if (i <= n) begin
        c = 4'((int'(ptr) + i) % n);
        if (req[c]) r = {1'b1, c};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick; the pointer register lives in the caller
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  request,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [MAX_CORES-1:0] req_ext;
  logic [4:0]           sel;

  assign req_ext = MAX_CORES'(request);
  assign sel     = rr_next(req_ext, 4'(ptr), N);
  assign valid   = sel[4];
  assign index   = IW'(sel[3:0]);
  assign grant   = valid ? (N'(1) << index) : '0;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - N cores sharing one single-port RAM, one round-robin transaction at a time
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int N_CORES = N_CORES_DEF,
  parameter int DW      = DW_DEF,
  parameter int CORE_AW = CORE_AW_DEF,
  parameter int RAM_AW  = RAM_AW_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CORES-1:0]      core_request,
  input  logic [N_CORES-1:0]      core_rw,
  input  logic [N_CORES*CORE_AW-1:0] core_address,
  input  logic [N_CORES*DW-1:0]   core_data_in,
  output logic [N_CORES-1:0]      core_grant,
  output logic [N_CORES-1:0]      core_err,
  output logic [N_CORES*DW-1:0]   core_data_out,
  output logic [RAM_AW-1:0]       RAM_address,
  output logic [DW-1:0]           RAM_data_in,
  input  logic [DW-1:0]           RAM_data_out,
  output logic                    rw_RAM
);

  localparam int IW = $clog2(N_CORES);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  bus_state_t        state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     owner;
  logic [CW-1:0]     cnt;
  logic              err_pend;

  logic [N_CORES-1:0] win_grant;
  logic [IW-1:0]      win_idx;
  logic               win_valid;
  logic               win_rw;
  logic [CORE_AW-1:0] win_addr;
  logic [DW-1:0]      win_data;
  logic               in_range;

  rr_arbiter #(.N(N_CORES), .IW(IW)) u_rr (
    .request (core_request),
    .ptr     (ptr),
    .grant   (win_grant),
    .index   (win_idx),
    .valid   (win_valid)
  );

  assign win_rw   = |(core_rw & win_grant);
  assign win_addr = core_address[win_idx*CORE_AW +: CORE_AW];
  assign win_data = core_data_in[win_idx*DW +: DW];
  assign in_range = (win_addr >> RAM_AW) == '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= IW'(N_CORES - 1);
      owner         <= '0;
      cnt           <= '0;
      err_pend      <= 1'b0;
      core_grant    <= '0;
      core_err      <= '0;
      core_data_out <= '0;
      RAM_address   <= '0;
      RAM_data_in   <= '0;
      rw_RAM        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            owner <= win_idx;
            ptr   <= win_idx;
            // Out-of-range accesses reuse the one-cycle WRITE slot with the strobe held low,
            // so the error grant lands with the same latency as a write.
            if (!in_range) begin
              err_pend <= 1'b1;
              state    <= WRITE;
            end else if (win_rw) begin
              err_pend    <= 1'b0;
              RAM_address <= win_addr[RAM_AW-1:0];
              RAM_data_in <= win_data;
              rw_RAM      <= 1'b1;
              state       <= WRITE;
            end else begin
              err_pend    <= 1'b0;
              RAM_address <= win_addr[RAM_AW-1:0];
              cnt         <= CW'(RD_LAT - 1);
              state       <= READ;
            end
          end
        end
        WRITE: begin
          rw_RAM            <= 1'b0;
          core_grant[owner] <= 1'b1;
          core_err[owner]   <= err_pend;
          state             <= GRANT;
        end
        READ: begin
          if (cnt == '0) begin
            core_data_out[owner*DW +: DW] <= RAM_data_out;
            core_grant[owner]             <= 1'b1;
            state                         <= GRANT;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        GRANT: begin
          core_grant <= '0;
          core_err   <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(core_grant));
  a_wr_single:    assert property (@(posedge clk) disable iff (!reset) rw_RAM |=> !rw_RAM);
  a_err_grant:    assert property (@(posedge clk) disable iff (!reset) (core_err & ~core_grant) == '0);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - randomized and directed bench with a transaction-level reference model
module tb_mem_bus_arbiter;

  localparam int N = 4, DW = 8, CAW = 10, RAW = 9, LAT1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [N-1:0]     core_request, core_rw, core_grant, core_err;
  logic [N*CAW-1:0] core_address;
  logic [N*DW-1:0]  core_data_in, core_data_out;
  logic [RAW-1:0]   RAM_address;
  logic [DW-1:0]    RAM_data_in, RAM_data_out;
  logic             rw_RAM;

  logic [N-1:0]     req3, rw3, grant3, err3;
  logic [N*CAW-1:0] addr3;
  logic [N*DW-1:0]  din3, dout3;
  logic [RAW-1:0]   raddr3;
  logic [DW-1:0]    rdin3, rdout3;
  logic             wr3;

  mem_bus_arbiter #(.N_CORES(N), .DW(DW), .CORE_AW(CAW), .RAM_AW(RAW), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .core_request(core_request), .core_rw(core_rw),
    .core_address(core_address), .core_data_in(core_data_in), .core_grant(core_grant),
    .core_err(core_err), .core_data_out(core_data_out), .RAM_address(RAM_address),
    .RAM_data_in(RAM_data_in), .RAM_data_out(RAM_data_out), .rw_RAM(rw_RAM));

  mem_bus_arbiter #(.N_CORES(N), .DW(DW), .CORE_AW(CAW), .RAM_AW(RAW), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .core_request(req3), .core_rw(rw3),
    .core_address(addr3), .core_data_in(din3), .core_grant(grant3),
    .core_err(err3), .core_data_out(dout3), .RAM_address(raddr3),
    .RAM_data_in(rdin3), .RAM_data_out(rdout3), .rw_RAM(wr3));

  // RAM behind dut: combinational read of the registered address (latency 1)
  logic [7:0] ram1 [512] = '{default: 8'h00};
  assign RAM_data_out = ram1[RAM_address];
  always @(posedge clk) if (rw_RAM) ram1[RAM_address] <= RAM_data_in;

  // RAM behind dut3: two extra pipeline stages (latency 3)
  logic [7:0] ram3 [512] = '{default: 8'h00};
  logic [7:0] p3a = 8'h00, p3b = 8'h00;
  assign rdout3 = p3b;
  always @(posedge clk) begin
    if (wr3) ram3[raddr3] <= rdin3;
    p3a <= ram3[raddr3];
    p3b <= p3a;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one transaction in flight, phase 0=idle 1=busy 2=grant cycle
  int ph, m_ptr, m_own, m_cyc, m_lat;
  bit m_wr, m_err;
  logic [9:0] m_addr;
  logic [7:0] m_data;
  logic [7:0] m_mem [512] = '{default: 8'h00};
  logic [N-1:0]    e_grant, e_err;
  logic            e_rw;
  logic [RAW-1:0]  e_raddr;
  logic [DW-1:0]   e_rdin;
  logic [N*DW-1:0] e_dout;

  task automatic model_reset();
    ph = 0; m_ptr = N - 1;
    e_grant = '0; e_err = '0; e_rw = 1'b0; e_raddr = '0; e_rdin = '0; e_dout = '0;
  endtask

  task automatic model_step();
    if (!reset) begin
      model_reset();
      return;
    end
    if (ph == 2) begin
      e_grant = '0; e_err = '0; ph = 0;
    end else if (ph == 1) begin
      m_cyc++;
      if (m_cyc == m_lat) begin
        e_rw = 1'b0;
        e_grant = '0; e_grant[m_own] = 1'b1;
        e_err = '0;
        if (m_err) e_err[m_own] = 1'b1;
        else if (m_wr) m_mem[m_addr[8:0]] = m_data;
        else e_dout[m_own*DW +: DW] = m_mem[m_addr[8:0]];
        ph = 2;
      end
    end else begin
      for (int i = 1; i <= N; i++) begin
        int c;
        c = (m_ptr + i) % N;
        if (core_request[c]) begin
          m_own = c; m_ptr = c; m_cyc = 0;
          m_addr = core_address[c*CAW +: CAW];
          m_data = core_data_in[c*DW +: DW];
          m_wr = core_rw[c];
          m_err = (m_addr >= 10'd512);
          m_lat = (m_err || m_wr) ? 1 : LAT1;
          if (!m_err) begin
            e_raddr = m_addr[8:0];
            if (m_wr) begin e_rdin = m_data; e_rw = 1'b1; end
          end
          ph = 1;
          break;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    model_step();
    chk("grant", core_grant, e_grant);
    chk("err", core_err, e_err);
    chk("rw_RAM", rw_RAM, e_rw);
    chk("RAM_address", RAM_address, e_raddr);
    chk("RAM_data_in", RAM_data_in, e_rdin);
    chk("data_out", core_data_out, e_dout);
    for (int i = 0; i < N; i++) if (e_grant[i]) core_request[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [9:0] a, input logic [7:0] d);
    core_rw[i] = w;
    core_address[i*CAW +: CAW] = a;
    core_data_in[i*DW +: DW] = d;
    core_request[i] = 1'b1;
  endtask

  task automatic run3(input logic w, input logic [9:0] a, input logic [7:0] d,
                      output int lat, output logic [7:0] rd);
    int n;
    rw3[3] = w; addr3[3*CAW +: CAW] = a; din3[3*DW +: DW] = d; req3[3] = 1'b1;
    n = 0; lat = -1;
    while (n < 20) begin
      step();
      n++;
      if (grant3[3]) begin lat = n - 1; break; end
    end
    req3[3] = 1'b0;
    rd = dout3[3*DW +: DW];
    chk("t5_timeout", lat >= 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int got[$];
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int lat;
    logic [7:0] rd;
    logic [9:0] a;

    core_request = '0; core_rw = '0; core_address = '0; core_data_in = '0;
    req3 = '0; rw3 = '0; addr3 = '0; din3 = '0;
    reset = 1'b1;
    #2 reset = 1'b0;
    model_reset();

    // reset holds outputs at zero whatever the inputs do
    repeat (3) begin
      @(negedge clk);
      core_request = 4'($urandom); core_rw = 4'($urandom);
      core_address = 40'({$urandom, $urandom}); core_data_in = 32'($urandom);
      #1;
      chk("rst_grant", core_grant, 0);
      chk("rst_err", core_err, 0);
      chk("rst_rw", rw_RAM, 0);
      chk("rst_addr", RAM_address, 0);
      chk("rst_din", RAM_data_in, 0);
      chk("rst_dout", core_data_out, 0);
    end
    @(negedge clk);
    core_request = '0; core_rw = '0;
    reset = 1'b1;
    model_reset();
    step();

    // test 1: core 2 writes 0xA5 @0x003
    set_req(2, 1'b1, 10'h003, 8'hA5);
    step();
    chk("t1_rw", rw_RAM, 1);
    chk("t1_addr", RAM_address, 9'h003);
    chk("t1_din", RAM_data_in, 8'hA5);
    chk("t1_nogrant", core_grant, 0);
    step();
    chk("t1_grant", core_grant, 4'b0100);
    chk("t1_rw_off", rw_RAM, 0);
    step();

    // test 2: core 0 reads it back
    set_req(0, 1'b0, 10'h003, 8'h00);
    step();
    chk("t2_nogrant", core_grant, 0);
    step();
    chk("t2_grant", core_grant, 4'b0001);
    chk("t2_data", core_data_out[7:0], 8'hA5);
    chk("t2_others", core_data_out[31:8], 0);
    step();

    // test 3: all cores read, re-raising after each grant
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    model_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 10'($urandom_range(0, 15)), 8'h00);
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      step();
      for (int i = 0; i < N; i++) if (core_grant[i]) got.push_back(i);
      for (int i = 0; i < N; i++) if (!core_request[i] && !e_grant[i]) core_request[i] = 1'b1;
    end
    chk("t3_count", got.size(), 6);
    for (int k = 0; k < got.size() && k < 6; k++) chk("t3_order", got[k], exp_order[k]);
    core_request = '0;
    repeat (4) step();

    // test 4: out-of-range write
    set_req(1, 1'b1, 10'h200, 8'h5A);
    step();
    chk("t4_rw", rw_RAM, 0);
    chk("t4_nogrant", core_grant, 0);
    step();
    chk("t4_grant", core_grant, 4'b0010);
    chk("t4_err", core_err, 4'b0010);
    chk("t4_rw2", rw_RAM, 0);
    step();
    chk("t4_ram", ram1[0], 8'h00);
    step();

    // test 6: reset in the middle of a write
    set_req(2, 1'b1, 10'h007, 8'h11);
    step();
    chk("t6_rw_on", rw_RAM, 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rw_async", rw_RAM, 0);
    chk("t6_nogrant", core_grant, 0);
    model_reset();
    set_req(0, 1'b0, 10'h003, 8'h00);
    @(negedge clk) reset = 1'b1;
    step();
    chk("t6_winner_addr", RAM_address, 9'h003);
    step();
    chk("t6_grant0", core_grant, 4'b0001);
    chk("t6_no_write", ram1[7], 8'h00);
    repeat (6) step();

    // test 5: RD_LAT=3 instance
    run3(1'b1, 10'h010, 8'h3C, lat, rd);
    step();
    run3(1'b1, 10'h011, 8'h77, lat, rd);
    step();
    run3(1'b0, 10'h010, 8'h00, lat, rd);
    chk("t5_lat", lat, 3);
    chk("t5_data", rd, 8'h3C);
    chk("t5_grant", grant3, 4'b1000);
    step();
    chk("t5_hold_addr", raddr3, 9'h010);
    run3(1'b0, 10'h011, 8'h00, lat, rd);
    chk("t5_lat2", lat, 3);
    chk("t5_data2", rd, 8'h77);

    // random traffic against the model
    for (int cyc = 0; cyc < 1500; cyc++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!core_request[i] && !e_grant[i] && $urandom_range(0, 3) == 0) begin
          a = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(512, 1023))
                                          : 10'($urandom_range(0, 15));
          set_req(i, 1'($urandom), a, 8'($urandom));
        end
      end
    end
    core_request = '0;
    repeat (6) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
